// File: rtl/nonrestoring_divider.sv
// Sequential radix-2 non-restoring integer divider. It produces one quotient bit per enabled cycle.
// Result timing is fixed: data_valid_o pulses DATA_WIDTH+1 enabled edges after a request is accepted.
module nonrestoring_divider #(
    parameter int DATA_WIDTH  = 32,
    parameter bit SIGNED_MODE = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clk_en_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic                  valid_entry_i,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  divide_by_zero_o,
    output logic                  data_valid_o,
    output logic                  busy_o,
    output logic [1:0]            state_o
);

    // Handshake: a request is taken on an enabled posedge where valid_entry_i=1 and the FSM is IDLE.
    // busy_o is high from the accept edge until the result edge. data_valid_o then pulses for
    // one enabled cycle. Requests that arrive while busy are dropped.
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIVIDE = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

    logic [1:0]            state_q;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH:0]   p_q;
    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] d_q;
    logic [DATA_WIDTH-1:0] dividend_raw_q;
    logic                  neg_q_q;
    logic                  neg_r_q;
    logic                  zero_q;

    logic                  dividend_neg;
    logic                  divisor_neg;
    logic [DATA_WIDTH-1:0] dividend_mag;
    logic [DATA_WIDTH-1:0] divisor_mag;
    logic [DATA_WIDTH:0]   d_ext;
    logic [DATA_WIDTH:0]   p_shift;
    logic [DATA_WIDTH:0]   p_next;
    logic [DATA_WIDTH:0]   rem_fix;
    logic [DATA_WIDTH-1:0] quot_res;
    logic [DATA_WIDTH-1:0] rem_res;

    always_comb begin
        dividend_neg = SIGNED_MODE && dividend_i[DATA_WIDTH-1];
        divisor_neg  = SIGNED_MODE && divisor_i[DATA_WIDTH-1];
        // The magnitude of MIN is held as an unsigned DATA_WIDTH-bit value, so negation is exact.
        dividend_mag = dividend_neg ? -dividend_i : dividend_i;
        divisor_mag  = divisor_neg  ? -divisor_i  : divisor_i;

        d_ext   = {1'b0, d_q};
        p_shift = {p_q[DATA_WIDTH-1:0], q_q[DATA_WIDTH-1]};
        p_next  = p_q[DATA_WIDTH] ? (p_shift + d_ext) : (p_shift - d_ext);

        rem_fix  = p_q[DATA_WIDTH] ? (p_q + d_ext) : p_q;
        quot_res = neg_q_q ? -q_q : q_q;
        rem_res  = neg_r_q ? -rem_fix[DATA_WIDTH-1:0] : rem_fix[DATA_WIDTH-1:0];
        if (zero_q) begin
            quot_res = '1;
            rem_res  = dividend_raw_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= ST_IDLE;
            count_q          <= '0;
            p_q              <= '0;
            q_q              <= '0;
            d_q              <= '0;
            dividend_raw_q   <= '0;
            neg_q_q          <= 1'b0;
            neg_r_q          <= 1'b0;
            zero_q           <= 1'b0;
            quotient_o       <= '0;
            remainder_o      <= '0;
            divide_by_zero_o <= 1'b0;
            data_valid_o     <= 1'b0;
        end else if (clk_en_i) begin
            data_valid_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (valid_entry_i) begin
                        state_q        <= ST_DIVIDE;
                        count_q        <= '0;
                        p_q            <= '0;
                        q_q            <= dividend_mag;
                        d_q            <= divisor_mag;
                        dividend_raw_q <= dividend_i;
                        neg_q_q        <= dividend_neg ^ divisor_neg;
                        neg_r_q        <= dividend_neg;
                        zero_q         <= (divisor_i == '0);
                    end
                end
                ST_DIVIDE: begin
                    p_q     <= p_next;
                    q_q     <= {q_q[DATA_WIDTH-2:0], ~p_next[DATA_WIDTH]};
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_COUNT) begin
                        state_q <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    quotient_o       <= quot_res;
                    remainder_o      <= rem_res;
                    divide_by_zero_o <= zero_q;
                    data_valid_o     <= 1'b1;
                    state_q          <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign state_o = state_q;

endmodule
